// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, widths, FSM encoding and op legality.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] ALU_XOR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Codes 3'b011..3'b111 have no ALU function and are answered with an error.
  function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_XOR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid line at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW:0] w_cand;
  logic        w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      if (!w_found && i_valid[w_cand[IW-1:0]]) begin
        w_found                 = 1'b1;
        o_idx                   = w_cand[IW-1:0];
        o_grant[w_cand[IW-1:0]] = 1'b1;
      end
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters: round-robin accept,
// drive the ALU, capture R/zero and hand the result back over valid/ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned OPW     = ALU_OPW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_ctrl,
  input  logic [WIDTH-1:0]         alu_r,
  input  logic                     alu_zero
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic [IDXW-1:0]     r_rr_ptr;
  logic [IDXW-1:0]     r_grant_idx;
  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [IDXW-1:0]     w_arb_idx;
  logic                w_arb_any;
  logic [WIDTH-1:0]    w_sel_a;
  logic [WIDTH-1:0]    w_sel_b;
  logic [OPW-1:0]      w_sel_op;
  logic                w_legal;
  logic                w_accept;
  logic                w_consume;
  logic [WIDTH-1:0]    r_alu_a;
  logic [WIDTH-1:0]    r_alu_b;
  logic [OPW-1:0]      r_alu_ctrl;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0]    r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_err;
  logic                r_busy;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDXW)
  ) u_rr_arbiter (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Payload mux for the requester the arbiter is picking this cycle.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == IDXW'(i)) begin
        w_sel_a  = req_a[i*WIDTH +: WIDTH];
        w_sel_b  = req_b[i*WIDTH +: WIDTH];
        w_sel_op = req_op[i*OPW +: OPW];
      end
    end
  end

  assign w_legal = is_legal_op(ALU_OPW'(w_sel_op));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_accept = 1'b1;
          w_next   = w_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: w_next = ST_CAPT;
      ST_CAPT: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[r_grant_idx]) begin
          w_consume = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Accept pulse is combinational so the transfer completes in the IDLE cycle.
  assign req_ready = (w_accept && reset) ? w_arb_grant : '0;

  // ALU operand registers only load on legal ops, so an illegal op leaves them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      if (w_accept) begin
        r_grant_idx <= w_arb_idx;
        if (w_legal) begin
          r_alu_a    <= w_sel_a;
          r_alu_b    <= w_sel_b;
          r_alu_ctrl <= w_sel_op;
        end else begin
          r_rsp_result <= '0;
          r_rsp_zero   <= 1'b1;
          r_rsp_err    <= 1'b1;
          r_rsp_valid  <= w_arb_grant;
        end
      end
      if (r_state == ST_CAPT) begin
        r_rsp_result <= alu_r;
        r_rsp_zero   <= alu_zero;
        r_rsp_err    <= 1'b0;
        r_rsp_valid  <= NUM_REQ'(1) << r_grant_idx;
      end
      if (w_consume) begin
        r_rsp_valid <= '0;
        r_rr_ptr    <= (r_grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_grant_idx + IDXW'(1);
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, scored against a transaction model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned OW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*OW-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '1;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           rsp_err;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OW-1:0]  alu_ctrl;
  logic [W-1:0]   alu_r = '0;
  logic           alu_zero;

  logic [W-1:0]   ra [N];
  logic [W-1:0]   rb [N];
  logic [OW-1:0]  rop[N];
  logic [N-1:0]   acc_flag = '0;
  logic [N-1:0]   hold = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t e_new;
  int   grant_log[$];
  int   gcyc_log[$];
  int   rsp_cnt[N];
  logic [W-1:0] last_res[N];
  logic last_zero[N];
  logic last_err[N];

  bit          m_idle = 1'b1;
  int          m_ptr = 0;
  int          m_grant = 0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [OW-1:0] m_ctrl = '0;
  int          pick;
  logic        legal;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .OPW(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]    = ra[i];
      req_b[i*W +: W]    = rb[i];
      req_op[i*OW +: OW] = rop[i];
    end
  end

  function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [OW-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Registered ALU stand-in with its own reset tied inactive.
  always @(posedge clk) alu_r <= alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_r == '0);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    return N'(1) << g;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: transaction model of round-robin service and response timing.
  always @(negedge clk) begin
    if (!reset) begin
      m_idle = 1'b1;
      m_ptr  = 0;
      m_a    = '0;
      m_b    = '0;
      m_ctrl = '0;
      exp_q.delete();
    end else begin
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      if (m_idle) begin
        pick = rr_pick(req_valid, m_ptr);
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        chk("req_ready", 32'(req_ready), (pick < 0) ? 32'd0 : 32'(onehot(pick)));
        if (pick >= 0) begin
          legal      = (rop[pick] <= 3'd2);
          e_new.idx  = pick;
          e_new.res  = legal ? alu_ref(ra[pick], rb[pick], rop[pick]) : '0;
          e_new.zero = (e_new.res == '0);
          e_new.err  = !legal;
          exp_q.push_back(e_new);
          if (legal) begin
            m_a    = ra[pick];
            m_b    = rb[pick];
            m_ctrl = rop[pick];
          end
          m_idle  = 1'b0;
          m_grant = pick;
          m_age   = 0;
          m_lat   = legal ? 3 : 1;
          acc_flag[pick] = 1'b1;
          grant_log.push_back(pick);
          gcyc_log.push_back(cyc);
        end
      end else begin
        m_age++;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("rsp_valid", 32'(rsp_valid), (m_age >= m_lat) ? 32'(onehot(m_grant)) : 32'd0);
        if (m_age == m_lat) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty grant=%0d", m_grant);
          end else begin
            cur = exp_q.pop_front();
            rsp_cnt[cur.idx]++;
          end
        end
        if (m_age >= m_lat) begin
          chk("rsp_result", rsp_result, cur.res);
          chk("rsp_zero", 32'(rsp_zero), 32'(cur.zero));
          chk("rsp_err", 32'(rsp_err), 32'(cur.err));
          last_res[m_grant]  = rsp_result;
          last_zero[m_grant] = rsp_zero;
          last_err[m_grant]  = rsp_err;
          if (rsp_ready[m_grant]) begin
            m_idle = 1'b1;
            m_ptr  = (m_grant + 1) % N;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (!hold[i]) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [OW-1:0] op);
    ra[i]  = a;
    rb[i]  = b;
    rop[i] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (!(m_idle && req_valid == '0 && acc_flag == '0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done timeout budget=%0d", budget);
    end
    tick();
  endtask

  task automatic reset_pulse();
    reset     = 1'b0;
    req_valid = '0;
    hold      = '0;
    acc_flag  = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_grant(string name, int pos, int exp);
    if (pos < grant_log.size()) begin
      chk(name, 32'(grant_log[pos]), 32'(exp));
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s missing grant at %0d, expected %0d", name, pos, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int base;
    int c3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [OW-1:0] op;

    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
      rsp_cnt[i] = 0; last_res[i] = '0; last_zero[i] = 1'b0; last_err[i] = 1'b0;
    end
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single ADD on requester 0.
    base = grant_log.size();
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    wait_done(20);
    chk_grant("t1_grant", base, 0);
    chk("t1_result", last_res[0], 32'd12);
    chk("t1_zero", 32'(last_zero[0]), 32'd0);
    chk("t1_err", 32'(last_err[0]), 32'd0);

    // All four requesters continuously valid.
    reset_pulse();
    base = grant_log.size();
    hold = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'd9, 32'd9, ALU_SUB);
    for (int n = 0; n < 60 && grant_log.size() < base + 5; n++) tick();
    hold      = '0;
    req_valid = '0;
    wait_done(20);
    chk_grant("t2_g0", base,     0);
    chk_grant("t2_g1", base + 1, 1);
    chk_grant("t2_g2", base + 2, 2);
    chk_grant("t2_g3", base + 3, 3);
    chk_grant("t2_g4", base + 4, 0);
    for (int k = 1; k < 5; k++) begin
      if (base + k < gcyc_log.size())
        chk("t2_spacing", 32'(gcyc_log[base+k] - gcyc_log[base+k-1]), 32'd4);
    end
    chk("t2_result", last_res[1], 32'd0);
    chk("t2_zero", 32'(last_zero[1]), 32'd1);

    // Back-pressured response with a competing request.
    base = grant_log.size();
    rsp_ready = '0;
    set_req(2, 32'hFFFF0000, 32'h0000FFFF, ALU_XOR);
    tick();
    set_req(1, 32'd1, 32'd2, ALU_ADD);
    for (int n = 0; n < 8; n++) tick();
    chk("t3_no_early_grant", 32'(grant_log.size()), 32'(base + 1));
    rsp_ready = '1;
    wait_done(20);
    chk_grant("t3_g0", base, 2);
    chk_grant("t3_g1", base + 1, 1);
    chk("t3_result", last_res[2], 32'hFFFFFFFF);

    // Illegal op code.
    set_req(1, 32'd3, 32'd4, 3'b101);
    wait_done(20);
    chk("t4_result", last_res[1], 32'd0);
    chk("t4_zero", 32'(last_zero[1]), 32'd1);
    chk("t4_err", 32'(last_err[1]), 32'd1);

    // Reset while the op is in EXEC.
    c3 = rsp_cnt[3];
    set_req(3, 32'd20, 32'd22, ALU_ADD);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rsp_result", rsp_result, 32'd0);
    chk("t5_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("t5_rsp_err", 32'(rsp_err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_alu_b", alu_b, 32'd0);
    chk("t5_alu_ctrl", 32'(alu_ctrl), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_no_rsp", 32'(rsp_cnt[3]), 32'(c3));
    set_req(3, 32'd20, 32'd22, ALU_ADD);
    wait_done(20);
    chk("t5_reissue_cnt", 32'(rsp_cnt[3]), 32'(c3 + 1));
    chk("t5_reissue_res", last_res[3], 32'd42);

    // Pointer at 3 with requesters 0 and 3 competing; wrapping add.
    reset_pulse();
    set_req(2, 32'd1, 32'd1, ALU_ADD);
    wait_done(20);
    base = grant_log.size();
    set_req(0, 32'hFFFFFFFF, 32'd1, ALU_ADD);
    set_req(3, 32'hFFFFFFFF, 32'd1, ALU_ADD);
    wait_done(30);
    chk_grant("t6_g0", base, 3);
    chk_grant("t6_g1", base + 1, 0);
    chk("t6_result", last_res[0], 32'd0);
    chk("t6_zero", 32'(last_zero[0]), 32'd1);

    // Random traffic, withdrawals and back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            set_req(i, a, b, op);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = N'($urandom);
      tick();
    end
    rsp_ready = '1;
    wait_done(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
